// File: rtl/ser2par_rx.sv
// Bit-serial to parallel frame receiver with a one-word valid/ready holding register.
// Frames of 1..DATA_WIDTH bits, MSB- or LSB-first, are right-justified; a word is dropped with sticky overflow if the register is full.
module ser2par_rx #(
    parameter  int DATA_WIDTH = 8,
    localparam int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic                  msb_first_i,
    input  logic                  bit_vld_i,
    input  logic                  ser_dat_i,
    output logic [DATA_WIDTH-1:0] par_data_o,
    output logic                  par_vld_o,
    input  logic                  par_rdy_i,
    output logic                  busy_o,
    output logic                  ovf_o,
    input  logic                  ovf_clr_i
);

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [LEN_W-1:0]      len_q, cnt_q;
    logic                  msb_q;
    logic [DATA_WIDTH-1:0] acc_q, data_q;
    logic                  vld_q, ovf_q;

    logic [LEN_W-1:0]      eff_len, base_len, base_cnt;
    logic                  base_msb;
    logic [DATA_WIDTH-1:0] base_acc, word;
    logic                  capture, done, load_ok;

    // A start in the same cycle as a strobe makes that bit bit 0 of the new frame,
    // so the frame context is taken from the inputs rather than the registers.
    always_comb begin
        eff_len  = (len_i == '0 || len_i > LEN_W'(DATA_WIDTH)) ? LEN_W'(DATA_WIDTH) : len_i;
        base_len = start_i ? eff_len     : len_q;
        base_cnt = start_i ? '0          : cnt_q;
        base_msb = start_i ? msb_first_i : msb_q;
        base_acc = start_i ? '0          : acc_q;
        capture  = bit_vld_i & (start_i | (state_q == RECV));
        done     = capture & (base_cnt == base_len - LEN_W'(1));
        load_ok  = ~vld_q | par_rdy_i;
        word     = base_acc;
        if (base_msb) begin
            word = {base_acc[DATA_WIDTH-2:0], ser_dat_i};
        end else begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (LEN_W'(i) == base_cnt) word[i] = ser_dat_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (done)         state_d = IDLE;
        else if (start_i) state_d = RECV;
    end

    always_comb begin
        busy_o     = (state_q == RECV);
        par_vld_o  = vld_q;
        par_data_o = data_q;
        ovf_o      = ovf_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q  <= LEN_W'(DATA_WIDTH);
            msb_q  <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (start_i) begin
                len_q <= eff_len;
                msb_q <= msb_first_i;
            end
            if (capture) begin
                acc_q <= word;
                cnt_q <= done ? '0 : base_cnt + LEN_W'(1);
            end else if (start_i) begin
                acc_q <= '0;
                cnt_q <= '0;
            end
            if (done && load_ok) begin
                data_q <= word;
                vld_q  <= 1'b1;
            end else if (vld_q && par_rdy_i) begin
                vld_q <= 1'b0;
            end
            // Set has priority over clear.
            ovf_q <= (done & ~load_ok) | (ovf_q & ~ovf_clr_i);
        end
    end

endmodule

// File: tb/tb_ser2par_rx.sv
// Directed-vector bench for ser2par_rx with immediate assertions at every check point.
module tb_ser2par_rx;

    logic       clk_i = 1'b0;
    logic       rst_i, start_i, msb_first_i, bit_vld_i, ser_dat_i, par_rdy_i, ovf_clr_i;
    logic [3:0] len_i;
    logic [7:0] par_data_o;
    logic       par_vld_o, busy_o, ovf_o;

    int n_checks = 0;
    int n_fail   = 0;

    ser2par_rx #(.DATA_WIDTH(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
        .msb_first_i(msb_first_i), .bit_vld_i(bit_vld_i), .ser_dat_i(ser_dat_i),
        .par_data_o(par_data_o), .par_vld_o(par_vld_o), .par_rdy_i(par_rdy_i),
        .busy_o(busy_o), .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bit_vld_i = 1'b1;
        ser_dat_i = b;
        tick();
        bit_vld_i = 1'b0;
    endtask

    // Start cycle (no bit), then len bits; optional clear / ready on the last-bit cycle.
    task automatic recv(input int len, input bit msb, input logic [7:0] d,
                        input bit clr_last, input bit rdy_last);
        logic saved;
        int   n;
        n = (len == 0) ? 8 : len;
        start_i     = 1'b1;
        len_i       = 4'(len);
        msb_first_i = msb;
        tick();
        start_i = 1'b0;
        saved   = par_rdy_i;
        for (int k = 0; k < n; k++) begin
            bit_vld_i = 1'b1;
            ser_dat_i = msb ? d[n-1-k] : d[k];
            if (k == n - 1) begin
                ovf_clr_i = clr_last;
                if (rdy_last) par_rdy_i = 1'b1;
            end
            tick();
        end
        bit_vld_i = 1'b0;
        ovf_clr_i = 1'b0;
        par_rdy_i = saved;
    endtask

    initial begin
        logic [7:0] pat;
        rst_i = 1'b1; start_i = 1'b0; len_i = 4'd0; msb_first_i = 1'b0;
        bit_vld_i = 1'b0; ser_dat_i = 1'b0; par_rdy_i = 1'b0; ovf_clr_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        chk("rst_vld", par_vld_o, 0);
        chk("rst_data", par_data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovf", ovf_o, 0);

        // MSB-first full width 0xB2
        par_rdy_i = 1'b1;
        start_i = 1'b1; len_i = 4'd8; msb_first_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("t1_busy_rise", busy_o, 1);
        pat = 8'hB2;
        for (int i = 7; i >= 1; i--) send_bit(pat[i]);
        chk("t1_vld_early", par_vld_o, 0);
        send_bit(pat[0]);
        chk("t1_vld", par_vld_o, 1);
        chk("t1_data", par_data_o, 32'hB2);
        chk("t1_busy_fall", busy_o, 0);
        tick();
        chk("t1_vld_one", par_vld_o, 0);
        chk("t1_data_hold", par_data_o, 32'hB2);

        // LSB-first len=3 with gaps, config changes mid-frame ignored
        start_i = 1'b1; len_i = 4'd3; msb_first_i = 1'b0;
        tick();
        start_i = 1'b0; len_i = 4'd8; msb_first_i = 1'b1;
        send_bit(1'b1); tick(); tick();
        send_bit(1'b1); tick(); tick();
        chk("t2_busy_mid", busy_o, 1);
        send_bit(1'b0);
        chk("t2_vld", par_vld_o, 1);
        chk("t2_lsb_data", par_data_o, 32'h03);
        tick();
        chk("t2_vld_fall", par_vld_o, 0);

        // same bits 1,1,0 MSB-first -> 0x06
        recv(3, 1'b1, 8'h06, 1'b0, 1'b0);
        chk("t2_msb_data", par_data_o, 32'h06);
        tick();
        // len=0 acts as 8
        recv(0, 1'b1, 8'hA5, 1'b0, 1'b0);
        chk("t2_len0_vld", par_vld_o, 1);
        chk("t2_len0_data", par_data_o, 32'hA5);
        tick();

        // Overflow
        par_rdy_i = 1'b0;
        recv(8, 1'b1, 8'h5A, 1'b0, 1'b0);
        chk("t3_first", par_data_o, 32'h5A);
        recv(8, 1'b1, 8'hC3, 1'b0, 1'b0);
        chk("t3_kept", par_data_o, 32'h5A);
        chk("t3_vld_held", par_vld_o, 1);
        chk("t3_ovf", ovf_o, 1);
        par_rdy_i = 1'b1;
        tick();
        par_rdy_i = 1'b0;
        chk("t3_accept_vld", par_vld_o, 0);
        chk("t3_ovf_sticky", ovf_o, 1);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        chk("t3_ovf_clr", ovf_o, 0);
        recv(8, 1'b0, 8'h12, 1'b0, 1'b0);
        chk("t3_load12", par_data_o, 32'h12);
        recv(8, 1'b0, 8'h34, 1'b1, 1'b0);
        chk("t3_set_wins", ovf_o, 1);
        chk("t3_kept12", par_data_o, 32'h12);
        ovf_clr_i = 1'b1; par_rdy_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        chk("t3_drain", par_vld_o, 0);
        chk("t3_clr2", ovf_o, 0);

        // Abort with same-cycle start + bit
        start_i = 1'b1; len_i = 4'd8; msb_first_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        start_i = 1'b1; bit_vld_i = 1'b1; ser_dat_i = 1'b1;
        tick();
        start_i = 1'b0; bit_vld_i = 1'b0;
        chk("t4_abort_vld", par_vld_o, 0);
        chk("t4_abort_busy", busy_o, 1);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        chk("t4_vld", par_vld_o, 1);
        chk("t4_data", par_data_o, 32'h80);
        chk("t4_ovf", ovf_o, 0);
        tick();
        chk("t4_one_word", par_vld_o, 0);
        start_i = 1'b1; len_i = 4'd1; bit_vld_i = 1'b1; ser_dat_i = 1'b1; msb_first_i = 1'b0;
        tick();
        start_i = 1'b0; bit_vld_i = 1'b0;
        chk("t4_len1_vld", par_vld_o, 1);
        chk("t4_len1_data", par_data_o, 32'h01);
        chk("t4_len1_busy", busy_o, 0);
        tick();

        // Drain-and-load
        par_rdy_i = 1'b0;
        recv(8, 1'b1, 8'h11, 1'b0, 1'b0);
        chk("t5_held", par_data_o, 32'h11);
        recv(8, 1'b1, 8'h22, 1'b0, 1'b1);
        chk("t5_vld", par_vld_o, 1);
        chk("t5_data", par_data_o, 32'h22);
        chk("t5_ovf", ovf_o, 0);
        tick();
        chk("t5_vld_hold", par_vld_o, 1);
        par_rdy_i = 1'b1;
        tick();
        chk("t5_drained", par_vld_o, 0);

        // Reset mid-operation
        par_rdy_i = 1'b0;
        recv(8, 1'b1, 8'h33, 1'b0, 1'b0);
        recv(8, 1'b1, 8'h44, 1'b0, 1'b0);
        start_i = 1'b1; len_i = 4'd8;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        chk("t6_pre_ovf", ovf_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("t6_vld", par_vld_o, 0);
        chk("t6_data", par_data_o, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_ovf", ovf_o, 0);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        tick();
        chk("t6_no_word", par_vld_o, 0);
        chk("t6_no_busy", busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
